multicycle_control: RTL and testbench

//  Sequencing FSM for the multi-cycle variant of the MIPS datapath. One shared memory serves

---
 rtl/multicycle_control_pkg.sv | 69 ++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control_output_decode.sv | 87 ++++++++
 rtl/multicycle_control.sv | 78 +++++++
 tb/tb_multicycle_control.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath select codes and the bundled control word.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_OR   = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_e;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_BGTZ, OP_ADDI, OP_ORI, OP_J: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode and flags in, enables/selects out.
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               zero;
    logic               msb;
    logic               mem_ready;
    logic               mem_rd;
    logic               mem_wr;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               ext_op;
    logic               reg_wr;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  opcode, zero, msb, mem_ready,
        output mem_rd, mem_wr, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, ext_op, reg_wr, reg_dst, mem_to_reg,
               illegal_op, state_o
    );

    modport slave (
        output opcode, zero, msb, mem_ready,
        input  mem_rd, mem_wr, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, ext_op, reg_wr, reg_dst, mem_to_reg,
               illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational map from FSM state (plus opcode, ALU flags and mem_ready for the
// Mealy terms) to the datapath control word.
module multicycle_control_output_decode
    import multicycle_control_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       msb,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: assigning the whole word first keeps every path latch-free and
        // makes unlisted outputs 0 in every state.
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.ext_op     = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_supported(opcode);
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_FUNC;
            end
            RWB: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
            IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = (opcode != OP_ORI);
                ctrl.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            IWB: ctrl.reg_wr = 1'b1;
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                case (opcode)
                    OP_BEQ:  ctrl.pc_write = zero;
                    OP_BNE:  ctrl.pc_write = !zero;
                    OP_BGTZ: ctrl.pc_write = !zero && !msb;
                    default: ctrl.pc_write = 1'b0;
                endcase
            end
            JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register and next-state logic; the output
// map lives in multicycle_control_output_decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl, ctrl_out;

    multicycle_control_output_decode u_decode (
        .state     (state_q),
        .opcode    (bus.opcode),
        .zero      (bus.zero),
        .msb       (bus.msb),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:             state_d = MEMADR;
                    OP_RTYPE:                 state_d = EXEC;
                    OP_BEQ, OP_BNE, OP_BGTZ:  state_d = BRANCH;
                    OP_J:                     state_d = JUMP;
                    OP_ADDI, OP_ORI:          state_d = IEXEC;
                    default:                  state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = RWB;
            IEXEC:  state_d = IWB;
            MEMWB, RWB, IWB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Outputs are forced quiet while reset is held so an abandoned access
    // cannot issue a stray write or load.
    always_comb begin
        ctrl_out = reset ? '0 : ctrl;
    end

    assign bus.mem_rd     = ctrl_out.mem_rd;
    assign bus.mem_wr     = ctrl_out.mem_wr;
    assign bus.iord       = ctrl_out.iord;
    assign bus.ir_write   = ctrl_out.ir_write;
    assign bus.pc_write   = ctrl_out.pc_write;
    assign bus.pc_src     = ctrl_out.pc_src;
    assign bus.alu_src_a  = ctrl_out.alu_src_a;
    assign bus.alu_src_b  = ctrl_out.alu_src_b;
    assign bus.alu_op     = ctrl_out.alu_op;
    assign bus.ext_op     = ctrl_out.ext_op;
    assign bus.reg_wr     = ctrl_out.reg_wr;
    assign bus.reg_dst    = ctrl_out.reg_dst;
    assign bus.mem_to_reg = ctrl_out.mem_to_reg;
    assign bus.illegal_op = ctrl_out.illegal_op;
    assign bus.state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: each cycle's stimulus and
// expected state/control word are queued, then replayed and compared.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control word field order:
    // mem_rd mem_wr iord ir_write pc_write pc_src alu_src_a alu_src_b alu_op ext_op reg_wr reg_dst mem_to_reg illegal_op
    localparam logic [16:0] E_ZERO       = 17'b0_0_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] E_FETCH_WAIT = 17'b1_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [16:0] E_FETCH_GO   = 17'b1_0_0_1_1_00_0_01_00_0_0_0_0_0;
    localparam logic [16:0] E_DECODE     = 17'b0_0_0_0_0_00_0_11_00_1_0_0_0_0;
    localparam logic [16:0] E_DECODE_ILL = 17'b0_0_0_0_0_00_0_11_00_1_0_0_0_1;
    localparam logic [16:0] E_MEMADR     = 17'b0_0_0_0_0_00_1_10_00_1_0_0_0_0;
    localparam logic [16:0] E_MEMRD      = 17'b1_0_1_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] E_MEMWB      = 17'b0_0_0_0_0_00_0_00_00_0_1_0_1_0;
    localparam logic [16:0] E_MEMWR      = 17'b0_1_1_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] E_EXEC       = 17'b0_0_0_0_0_00_1_00_10_0_0_0_0_0;
    localparam logic [16:0] E_RWB        = 17'b0_0_0_0_0_00_0_00_00_0_1_1_0_0;
    localparam logic [16:0] E_IEXEC_ADDI = 17'b0_0_0_0_0_00_1_10_00_1_0_0_0_0;
    localparam logic [16:0] E_IEXEC_ORI  = 17'b0_0_0_0_0_00_1_10_11_0_0_0_0_0;
    localparam logic [16:0] E_IWB        = 17'b0_0_0_0_0_00_0_00_00_0_1_0_0_0;
    localparam logic [16:0] E_BR_TAKEN   = 17'b0_0_0_0_1_01_1_00_01_0_0_0_0_0;
    localparam logic [16:0] E_BR_NOT     = 17'b0_0_0_0_0_01_1_00_01_0_0_0_0_0;
    localparam logic [16:0] E_JUMP       = 17'b0_0_0_0_1_10_0_00_00_0_0_0_0_0;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic [5:0]  op;
        logic        z;
        logic        m;
        logic [3:0]  st;
        logic [16:0] ex;
    } step_t;

    step_t sb_q[$];
    string tag_q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [16:0] observed();
        return {bus.mem_rd, bus.mem_wr, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.ext_op, bus.reg_wr, bus.reg_dst, bus.mem_to_reg,
                bus.illegal_op};
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic [5:0] op,
                        input logic z, input logic m, input logic [3:0] st,
                        input logic [16:0] ex, input string tag);
        step_t s;
        s.rst = rst;
        s.rdy = rdy;
        s.op  = op;
        s.z   = z;
        s.m   = m;
        s.st  = st;
        s.ex  = ex;
        sb_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    task automatic fetch_go(input logic [5:0] op);
        push(1'b0, 1'b1, op, 1'b0, 1'b0, 4'd0, E_FETCH_GO, "fetch");
    endtask

    task automatic decode(input logic [5:0] op);
        push(1'b0, 1'b1, op, 1'b0, 1'b0, 4'd1, E_DECODE, "decode");
    endtask

    // Drive each queued cycle at the falling edge, compare 1 ns later.
    task automatic drain();
        while (sb_q.size() > 0) begin
            step_t s;
            string t;
            logic [16:0] obs;
            s = sb_q.pop_front();
            t = tag_q.pop_front();
            @(negedge clk);
            reset         = s.rst;
            bus.mem_ready = s.rdy;
            bus.opcode    = s.op;
            bus.zero      = s.z;
            bus.msb       = s.m;
            #1;
            checks++;
            assert (bus.state_o === s.st) else begin
                failures++;
                $error("FAIL %s state observed=%0d expected=%0d", t, bus.state_o, s.st);
            end
            obs = observed();
            checks++;
            assert (obs === s.ex) else begin
                failures++;
                $error("FAIL %s ctrl observed=%b expected=%b", t, obs, s.ex);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "simulation timeout");
    end

    initial begin
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;
        bus.msb       = 1'b0;
        bus.mem_ready = 1'b0;
        reset         = 1'b1;

        // Reset held: everything quiet, state 0.
        push(1'b1, 1'b0, OP_LW, 1'b0, 1'b0, 4'd0, E_ZERO, "reset_hold");
        push(1'b1, 1'b1, OP_LW, 1'b0, 1'b0, 4'd0, E_ZERO, "reset_hold_rdy");

        // lw, zero-wait memory: 0,1,2,3,4.
        fetch_go(OP_LW);
        decode(OP_LW);
        push(1'b0, 1'b1, OP_LW, 1'b0, 1'b0, 4'd2, E_MEMADR, "lw_memadr");
        push(1'b0, 1'b1, OP_LW, 1'b0, 1'b0, 4'd3, E_MEMRD, "lw_memrd");
        push(1'b0, 1'b1, OP_LW, 1'b0, 1'b0, 4'd4, E_MEMWB, "lw_memwb");

        // sw with three wait cycles in MEMWR.
        fetch_go(OP_SW);
        decode(OP_SW);
        push(1'b0, 1'b1, OP_SW, 1'b0, 1'b0, 4'd2, E_MEMADR, "sw_memadr");
        for (int i = 0; i < 3; i++)
            push(1'b0, 1'b0, OP_SW, 1'b0, 1'b0, 4'd5, E_MEMWR, "sw_wait");
        push(1'b0, 1'b1, OP_SW, 1'b0, 1'b0, 4'd5, E_MEMWR, "sw_done");

        // Branch variants.
        fetch_go(OP_BEQ);
        decode(OP_BEQ);
        push(1'b0, 1'b1, OP_BEQ, 1'b1, 1'b0, 4'd8, E_BR_TAKEN, "beq_z1");
        fetch_go(OP_BEQ);
        decode(OP_BEQ);
        push(1'b0, 1'b1, OP_BEQ, 1'b0, 1'b0, 4'd8, E_BR_NOT, "beq_z0");
        fetch_go(OP_BNE);
        decode(OP_BNE);
        push(1'b0, 1'b1, OP_BNE, 1'b0, 1'b0, 4'd8, E_BR_TAKEN, "bne_z0");
        fetch_go(OP_BGTZ);
        decode(OP_BGTZ);
        push(1'b0, 1'b1, OP_BGTZ, 1'b0, 1'b1, 4'd8, E_BR_NOT, "bgtz_neg");
        fetch_go(OP_BGTZ);
        decode(OP_BGTZ);
        push(1'b0, 1'b1, OP_BGTZ, 1'b0, 1'b0, 4'd8, E_BR_TAKEN, "bgtz_pos");

        // R-type.
        fetch_go(OP_RTYPE);
        decode(OP_RTYPE);
        push(1'b0, 1'b1, OP_RTYPE, 1'b0, 1'b0, 4'd6, E_EXEC, "r_exec");
        push(1'b0, 1'b1, OP_RTYPE, 1'b0, 1'b0, 4'd7, E_RWB, "r_wb");

        // addi and ori.
        fetch_go(OP_ADDI);
        decode(OP_ADDI);
        push(1'b0, 1'b1, OP_ADDI, 1'b0, 1'b0, 4'd10, E_IEXEC_ADDI, "addi_exec");
        push(1'b0, 1'b1, OP_ADDI, 1'b0, 1'b0, 4'd11, E_IWB, "addi_wb");
        fetch_go(OP_ORI);
        decode(OP_ORI);
        push(1'b0, 1'b1, OP_ORI, 1'b0, 1'b0, 4'd10, E_IEXEC_ORI, "ori_exec");
        push(1'b0, 1'b1, OP_ORI, 1'b0, 1'b0, 4'd11, E_IWB, "ori_wb");

        // Jump.
        fetch_go(OP_J);
        decode(OP_J);
        push(1'b0, 1'b1, OP_J, 1'b0, 1'b0, 4'd9, E_JUMP, "j_jump");

        // Unsupported opcode: pulse in DECODE, straight back to FETCH.
        fetch_go(6'b111111);
        push(1'b0, 1'b1, 6'b111111, 1'b0, 1'b0, 4'd1, E_DECODE_ILL, "illegal_decode");

        // FETCH waits on memory.
        push(1'b0, 1'b0, OP_LW, 1'b0, 1'b0, 4'd0, E_FETCH_WAIT, "fetch_wait");
        push(1'b0, 1'b0, OP_LW, 1'b0, 1'b0, 4'd0, E_FETCH_WAIT, "fetch_wait2");

        // lw stalled in MEMRD, then reset abandons the access.
        fetch_go(OP_LW);
        decode(OP_LW);
        push(1'b0, 1'b1, OP_LW, 1'b0, 1'b0, 4'd2, E_MEMADR, "lw2_memadr");
        push(1'b0, 1'b0, OP_LW, 1'b0, 1'b0, 4'd3, E_MEMRD, "lw2_memrd_wait");
        push(1'b1, 1'b0, OP_LW, 1'b0, 1'b0, 4'd0, E_ZERO, "reset_mid_memrd");
        push(1'b1, 1'b1, OP_LW, 1'b0, 1'b0, 4'd0, E_ZERO, "reset_mid_rdy");
        push(1'b0, 1'b0, OP_LW, 1'b0, 1'b0, 4'd0, E_FETCH_WAIT, "post_reset_fetch");

        // Normal operation resumes.
        fetch_go(OP_J);
        decode(OP_J);
        push(1'b0, 1'b1, OP_J, 1'b0, 1'b0, 4'd9, E_JUMP, "j2_jump");
        push(1'b0, 1'b0, OP_J, 1'b0, 1'b0, 4'd0, E_FETCH_WAIT, "final_fetch");

        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
